fetch_sequencer: RTL and testbench

Front-end controller for the axis_cpu pipeline. Owns the program counter, issues synchronous reads to code memory and presents fetched instructions to the delay stage with a valid/ready handshake. Drives the `PC_en` strobe and per-instruction wait `icount` consumed by the delay stage. Redirects fetch on branch mispredict, discarding the in-flight instruction.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: owns the PC, issues code-memory reads and hands
// fetched instructions to the delay stage over a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   branch_mispredict,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   rd_en,
  output logic [PC_WIDTH-1:0]    rd_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   vld,
  input  logic                   next_rdy,
  output logic                   PC_en,
  output logic [COUNT_WIDTH-1:0] icount,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   pending_q, pending_d;
  logic [COUNT_WIDTH-1:0] icount_q, icount_d;
  logic                   handshake;
  logic [COUNT_WIDTH-1:0] icount_inc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      pending_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      icount_q  <= icount_d;
    end
  end

  assign handshake  = pending_q && next_rdy;
  assign icount_inc = (icount_q == CNT_MAX) ? icount_q : icount_q + COUNT_WIDTH'(1);

  // Next-state, issue and handshake decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    icount_d  = icount_q;
    rd_en     = 1'b0;
    PC_en     = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          pending_d = 1'b0;
          icount_d  = '0;
        end
      end
      S_FETCH: begin
        if (branch_mispredict) begin
          pc_d      = branch_target;
          pending_d = 1'b0;
          icount_d  = '0;
        end else if (halt) begin
          // An instruction accepted in the halt cycle leaves nothing to drain
          if (handshake || !pending_q) begin
            PC_en     = handshake;
            pending_d = 1'b0;
            icount_d  = '0;
            state_d   = S_HALTED;
          end else begin
            icount_d = icount_inc;
            state_d  = S_DRAIN;
          end
        end else if (!pending_q || next_rdy) begin
          rd_en     = 1'b1;
          PC_en     = handshake;
          pc_d      = pc_q + PC_WIDTH'(1);
          pending_d = 1'b1;
          icount_d  = '0;
        end else begin
          icount_d = icount_inc;
        end
      end
      S_DRAIN: begin
        if (branch_mispredict) begin
          pc_d      = branch_target;
          pending_d = 1'b0;
          icount_d  = '0;
          state_d   = S_FETCH;
        end else if (handshake) begin
          PC_en     = 1'b1;
          pending_d = 1'b0;
          icount_d  = '0;
          state_d   = S_HALTED;
        end else if (!pending_q) begin
          state_d = S_HALTED;
        end else begin
          icount_d = icount_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr   = pc_q;
  assign vld       = pending_q;
  assign icount    = icount_q;
  assign instr_out = mem_rdata;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a behavioural fetch model,
// with directed scenarios that pin the model to hand-computed values.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       branch_mispredict = 1'b0;
  logic [7:0] branch_target = 8'd0;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] mem_rdata = 8'd0;
  logic [7:0] instr_out;
  logic       vld;
  logic       next_rdy = 1'b0;
  logic       PC_en;
  logic [5:0] icount;
  logic       busy;

  logic [7:0] mem [256];

  int passed = 0;
  int total  = 0;

  // Model: mode 0 idle, 1 fetching, 2 draining, 3 halted
  int m_mode = 0;
  int m_pc   = 0;
  bit m_pend = 1'b0;
  int m_addr = 0;
  int m_wait = 0;

  fetch_sequencer #(.PC_WIDTH(8), .INSTR_WIDTH(8), .COUNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .branch_mispredict(branch_mispredict), .branch_target(branch_target),
    .rd_en(rd_en), .rd_addr(rd_addr), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .vld(vld), .next_rdy(next_rdy), .PC_en(PC_en),
    .icount(icount), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous code memory: data the cycle after rd_en, held otherwise
  always @(posedge clk) if (rd_en) mem_rdata <= mem[rd_addr];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_pend = 1'b0; m_addr = 0; m_wait = 0;
  endtask

  task automatic step(input bit s, input bit h, input bit mp, input int tgt, input bit rdy);
    bit issue, accept, fetching, draining;
    @(negedge clk);
    start = s; halt = h; branch_mispredict = mp; branch_target = 8'(tgt); next_rdy = rdy;
    #1;
    fetching = (m_mode == 1);
    draining = (m_mode == 2);
    issue    = fetching && !mp && !h && (!m_pend || rdy);
    accept   = m_pend && rdy && !mp;
    check("rd_en",  int'(rd_en),   int'(issue));
    check("rd_addr", int'(rd_addr), m_pc);
    check("vld",    int'(vld),     int'(m_pend));
    check("PC_en",  int'(PC_en),   int'(accept));
    check("icount", int'(icount),  m_wait);
    check("busy",   int'(busy),    int'(fetching || draining));
    if (m_pend) check("instr_out", int'(instr_out), int'(mem[m_addr]));
    if (m_mode == 0 || m_mode == 3) begin
      if (s) begin m_mode = 1; m_pc = 0; m_pend = 1'b0; m_wait = 0; end
    end else if (mp) begin
      m_mode = 1; m_pc = tgt; m_pend = 1'b0; m_wait = 0;
    end else begin
      if (accept) begin m_pend = 1'b0; m_wait = 0; end
      else if (m_pend) m_wait = (m_wait + 1 > 63) ? 63 : m_wait + 1;
      if (issue) begin m_addr = m_pc; m_pc = (m_pc + 1) % 256; m_pend = 1'b1; m_wait = 0; end
      if ((fetching && h) || draining) m_mode = m_pend ? 2 : 3;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_vld", int'(vld), 0);
    check("rst_PC_en", int'(PC_en), 0);
    check("rst_icount", int'(icount), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk); #1;
    check_reset_outputs();
    @(negedge clk); rst_n = 1'b1;

    // Start and stream with next_rdy high
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1); check("lit_addr0", int'(rd_addr), 0); check("lit_vld0", int'(vld), 0);
    step(0, 0, 0, 0, 1); check("lit_addr1", int'(rd_addr), 1); check("lit_pcen1", int'(PC_en), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1); check("lit_addr3", int'(rd_addr), 3); check("lit_icnt0", int'(icount), 0);

    // Five-cycle backpressure
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("lit_stall_icount", int'(icount), 5);
    check("lit_stall_pcen", int'(PC_en), 1);
    check("lit_stall_addr", int'(rd_addr), 4);

    // Saturation of the wait counter
    for (int i = 0; i < 70; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("lit_sat_icount", int'(icount), 63);

    // Mispredict at PC 5 while an instruction is pending
    step(0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0); check("lit_redir4", int'(rd_addr), 4);
    step(0, 0, 1, 8'h40, 1);
    check("lit_mp_addr5", int'(rd_addr), 5);
    check("lit_mp_pcen", int'(PC_en), 0);
    step(0, 0, 0, 0, 0);
    check("lit_mp_vld", int'(vld), 0);
    check("lit_mp_target", int'(rd_addr), 8'h40);
    check("lit_mp_rden", int'(rd_en), 1);
    step(0, 0, 0, 0, 0); check("lit_mp_vld2", int'(vld), 1);

    // PC wrap
    step(0, 0, 1, 8'hFF, 0);
    step(0, 0, 0, 0, 1); check("lit_addrff", int'(rd_addr), 255);
    step(0, 0, 0, 0, 1); check("lit_wrap", int'(rd_addr), 0); check("lit_wrap_rden", int'(rd_en), 1);

    // Halt with pending instruction and backpressure
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); check("lit_drain_busy", int'(busy), 1); check("lit_drain_rden", int'(rd_en), 0);
    step(0, 0, 0, 0, 1); check("lit_drain_pcen", int'(PC_en), 1);
    step(0, 0, 0, 0, 0); check("lit_halted_busy", int'(busy), 0); check("lit_halted_vld", int'(vld), 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1); check("lit_restart_addr", int'(rd_addr), 0); check("lit_restart_rden", int'(rd_en), 1);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk); rst_n = 1'b0;
        start = 1'b0; halt = 1'b0; branch_mispredict = 1'b0; next_rdy = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk); rst_n = 1'b1;
      end
      step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 8, int'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 70);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
